// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } sub_state_t;

endpackage

// File: rtl/serial_sub_fsub1.sv
// Combinational full-subtractor cell built from two half-subtractors.
module fsub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  // First half: a - b
  assign d1 = a ^ b;
  assign b1 = ~a & b;

  // Second half: (a - b) - bin
  assign d  = d1 ^ bin;
  assign b2 = ~d1 & bin;

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through one fsub1 cell.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_sub: WIDTH out of range");
  end

  sub_state_t       state;
  sub_state_t       state_n;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic             d;
  logic             brw_n;
  logic             load;
  logic             step;
  logic             last;

  fsub1 u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (brw),
    .d    (d),
    .bout (brw_n)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and control decode
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          last    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign out_valid = (state == DONE);

  // Serial datapath; result is staged in acc and published only on the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      acc  <= '0;
      cnt  <= '0;
      brw  <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      if (load) begin
        sa  <= a;
        sb  <= b;
        brw <= bin;
        cnt <= '0;
      end
      if (step) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        brw <= brw_n;
        cnt <= cnt + CNT_W'(1);
        acc <= WIDTH'({d, acc} >> 1);
      end
      if (last) begin
        diff <= WIDTH'({d, acc} >> 1);
        bout <= brw_n;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Signed overflow: borrow into the MSB step differs from borrow out of it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ovf <= 1'b0;
    else if (last) ovf <= brw ^ brw_n;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
